bg_trim_seq: RTL
================

Name: bg_trim_seq

Overview:
- Synchronous sequencer that drives the digital control pins of the bandgap core: IDAC, diode bank, resistor selects and the two switched-capacitor cells.
- Powers up the core, waits for settling, then runs two-phase diode-ratio sampling conversions with non-overlapping capacitor switching.
- Optionally runs an MSB-first successive-approximation trim of the fine IDAC code using an external comparator on VP/VN.
- Optional chopping swaps the roles of the two capacitor cells.

Parameters:
- IDAC_W, 8: width of the fine and coarse IDAC codes, and the number of SAR steps.
- NDIODE, 8: width of the diode-bank select.
- NCH, 4: number of IDAC output branches.
- SETTLE_CYC, 64: power-up settle time in cycles, minimum 1.
- PHASE_CYC, 16: length of each S1/S2/HOLD phase in cycles, minimum 2.
- NOVL_CYC, 2: non-overlap gap length in cycles, minimum 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- en  in  1  block enable; low forces power-down
- start  in  1  start request, sampled level
- trim_en  in  1  1 = SAR trim, 0 = single conversion using idac_fine_cfg
- chop_en  in  1  swap capacitor roles on odd conversions
- cmp  in  1  comparator result (VP>VN), already synchronous to clk
- idac_coarse_cfg  in  IDAC_W  coarse IDAC code
- idac_fine_cfg  in  IDAC_W  fine code used when trim_en=0
- out_sel_n_cfg  in  NCH  IDAC output enables, active low
- diode_n_cfg  in  NDIODE  diode mask for the S2 ("N diodes") phase
- pwrup  out  1  core power-up
- idac_fine  out  IDAC_W  fine code to the IDAC
- idac_coarse  out  IDAC_W  coarse code to the IDAC
- idac_out_sel_n  out  NCH  IDAC branch enables, active low
- diode_sel  out  NDIODE  diode bank select
- res_stable_sel  out  1  resistor stable-bias select
- res_ptat_en_n  out  1  PTAT resistor enable, active low
- c1  out  2  capacitor cell 1: bit0 connects to the IDAC node, bit1 connects to the output
- c2  out  2  capacitor cell 2, same encoding as c1
- busy  out  1  high from SETTLE through the last gap
- done  out  1  one-cycle completion pulse
- trim_code  out  IDAC_W  result register

Behaviour:
- Reset (reset_n=0 at a clk edge) sets the state to IDLE and all outputs to reset values on that edge:
  - pwrup=0, idac_fine=0, idac_coarse=0, trim_code=0
  - idac_out_sel_n=all 1s, diode_sel=0, res_stable_sel=0, res_ptat_en_n=1
  - c1=c2=00, busy=0, done=0
- Reset mid-conversion aborts immediately. No partial trim_code update is kept.
- States: IDLE, SETTLE, S1, G1, S2, G2, HOLD, G3, DONE, READY.
- IDLE: all outputs at reset values. With en=1 and start=1, go to SETTLE. In SETTLE, pwrup=1, busy=1, res_ptat_en_n=0, and idac_coarse/out_sel_n are loaded from cfg.
- SETTLE lasts SETTLE_CYC cycles, then goes to S1 with conversion index k=0.
- One conversion is S1 (PHASE_CYC) -> G1 (NOVL_CYC) -> S2 (PHASE_CYC) -> G2 (NOVL_CYC) -> HOLD (PHASE_CYC) -> G3 (NOVL_CYC), 3*PHASE_CYC+3*NOVL_CYC cycles total (54 at defaults).
- Phase outputs, when not swapped:
  - S1: diode_sel=one-hot bit0, c1=01, c2=00.
  - S2: diode_sel=diode_n_cfg, c1=00, c2=01.
  - HOLD: c1=10, c2=10, diode_sel=diode_n_cfg.
  - Gaps: c1=c2=00, diode_sel holds its previous value.
- Swap (chop_en=1 and k odd): c1 and c2 values are exchanged in S1/S2, and the effective comparator value is ~cmp.
- Break-before-make: c1 and c2 are never both nonzero, except in HOLD. Any nonzero c bit is preceded by at least NOVL_CYC cycles of 00.
- SAR (trim_en=1):
  - Entering S1 of conversion k sets bit (IDAC_W-1-k) of the working code; idac_fine shows the working code.
  - Effective cmp is sampled on the last HOLD cycle. If it is 0, that bit is cleared at the G3 entry.
  - Runs IDAC_W conversions. Working code starts at 0.
- trim_en=0: exactly one conversion with idac_fine=idac_fine_cfg; trim_code=idac_fine_cfg.
- After the last G3 cycle, enter DONE for one cycle: done=1, busy=0, trim_code updated, c=00. Then go to READY.
- READY: pwrup=1, idac_fine=trim_code, c=00, diode_sel=0.
  - start=1 goes directly to S1, skipping SETTLE.
  - Configuration inputs are sampled only in SETTLE or on leaving READY.
- en=0 in any state returns to IDLE on the next edge, with reset-value outputs except that trim_code is held.
- start while busy is ignored. start and en=0 together: en wins.

Test Plan:
- Reset with all inputs at 1 -> every output at its reset value, including idac_out_sel_n=4'hF.
- Default parameters, trim_en=0, idac_fine_cfg=0x5A, start at cycle 0 -> busy from cycle 1, pwrup=1 for 64 cycles then the S1 phase; done exactly at cycle 1+64+54; trim_code=0x5A; READY entered.
- trim_en=1, cmp model returns 1 while code<=0x93 -> 8 conversions, trim_code=0x93, done at cycle 1+64+8*54.
- chop_en=1 with the same model and cmp inverted on odd k -> trim_code=0x93; c1/c2 visibly swapped in S1/S2 of odd conversions; no cycle has c1!=0 and c2!=0 outside HOLD.
- en dropped during S2 of conversion 3 -> next cycle IDLE, pwrup=0, trim_code holds its previous value, no done pulse.
- start from READY -> S1 on the next cycle with no SETTLE; a start pulse mid-conversion has no effect.

Source files
------------

// File: rtl/bg_trim_seq.sv
// Bandgap core control sequencer: power-up, settle, two-phase diode-ratio sampling
// conversions with non-overlapping cap switching, and optional SAR trim of the fine IDAC code.
module bg_trim_seq #(
    parameter int unsigned IDAC_W     = 8,
    parameter int unsigned NDIODE     = 8,
    parameter int unsigned NCH        = 4,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned PHASE_CYC  = 16,
    parameter int unsigned NOVL_CYC   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              start,
    input  logic              trim_en,
    input  logic              chop_en,
    input  logic              cmp,
    input  logic [IDAC_W-1:0] idac_coarse_cfg,
    input  logic [IDAC_W-1:0] idac_fine_cfg,
    input  logic [NCH-1:0]    out_sel_n_cfg,
    input  logic [NDIODE-1:0] diode_n_cfg,
    output logic              pwrup,
    output logic [IDAC_W-1:0] idac_fine,
    output logic [IDAC_W-1:0] idac_coarse,
    output logic [NCH-1:0]    idac_out_sel_n,
    output logic [NDIODE-1:0] diode_sel,
    output logic              res_stable_sel,
    output logic              res_ptat_en_n,
    output logic [1:0]        c1,
    output logic [1:0]        c2,
    output logic              busy,
    output logic              done,
    output logic [IDAC_W-1:0] trim_code
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] SETTLE = 4'd1;
    localparam logic [3:0] S1     = 4'd2;
    localparam logic [3:0] G1     = 4'd3;
    localparam logic [3:0] S2     = 4'd4;
    localparam logic [3:0] G2     = 4'd5;
    localparam logic [3:0] HOLD   = 4'd6;
    localparam logic [3:0] G3     = 4'd7;
    localparam logic [3:0] DONE   = 4'd8;
    localparam logic [3:0] READY  = 4'd9;

    localparam int unsigned MAX_A   = (SETTLE_CYC > PHASE_CYC) ? SETTLE_CYC : PHASE_CYC;
    localparam int unsigned MAX_LEN = (MAX_A > NOVL_CYC) ? MAX_A : NOVL_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned KW      = $clog2(IDAC_W + 1);
    localparam logic [IDAC_W-1:0] MSB = IDAC_W'(1) << (IDAC_W - 1);

    logic [3:0]        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_last;
    logic [KW-1:0]     k;
    logic [IDAC_W-1:0] work;
    logic [IDAC_W-1:0] coarse_q, fine_q;
    logic [NCH-1:0]    sel_n_q;
    logic [NDIODE-1:0] diode_n_q;
    logic              trim_q, chop_q;
    logic              phase_end, conv_last, swap, eff_cmp, cfg_load;

    assign swap      = chop_q & k[0];
    assign eff_cmp   = cmp ^ swap;
    assign phase_end = (cnt == cnt_last);
    assign conv_last = trim_q ? (k == KW'(IDAC_W - 1)) : 1'b1;
    assign cfg_load  = en & ((state == IDLE && start) || state == SETTLE || (state == READY && start));

    always_comb begin
        cnt_last = '0;
        case (state)
            SETTLE:         cnt_last = CNT_W'(SETTLE_CYC - 1);
            S1, S2, HOLD:   cnt_last = CNT_W'(PHASE_CYC - 1);
            G1, G2, G3:     cnt_last = CNT_W'(NOVL_CYC - 1);
            default:        cnt_last = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SETTLE;
            SETTLE:  if (phase_end) state_nx = S1;
            S1:      if (phase_end) state_nx = G1;
            G1:      if (phase_end) state_nx = S2;
            S2:      if (phase_end) state_nx = G2;
            G2:      if (phase_end) state_nx = HOLD;
            HOLD:    if (phase_end) state_nx = G3;
            G3:      if (phase_end) state_nx = conv_last ? DONE : S1;
            DONE:    state_nx = READY;
            READY:   if (start) state_nx = S1;
            default: state_nx = IDLE;
        endcase
        if (!en) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            k         <= '0;
            work      <= '0;
            trim_code <= '0;
            coarse_q  <= '0;
            fine_q    <= '0;
            sel_n_q   <= '1;
            diode_n_q <= '0;
            trim_q    <= 1'b0;
            chop_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? '0 : cnt + CNT_W'(1);
            if (cfg_load) begin
                coarse_q  <= idac_coarse_cfg;
                fine_q    <= idac_fine_cfg;
                sel_n_q   <= out_sel_n_cfg;
                diode_n_q <= diode_n_cfg;
                trim_q    <= trim_en;
                chop_q    <= chop_en;
            end
            // SAR: set the trial bit on S1 entry, clear it on G3 entry if the comparator says too high
            if (state_nx == S1 && state != S1) begin
                if (state == G3) begin
                    k    <= k + KW'(1);
                    work <= work | (MSB >> (k + KW'(1)));
                end else begin
                    k    <= '0;
                    work <= MSB;
                end
            end else if (state == HOLD && state_nx == G3 && !eff_cmp) begin
                work <= work & ~(MSB >> k);
            end
            if (state_nx == DONE && state != DONE)
                trim_code <= trim_q ? work : fine_q;
        end
    end

    always_comb begin
        pwrup          = 1'b0;
        idac_fine      = '0;
        idac_coarse    = '0;
        idac_out_sel_n = '1;
        diode_sel      = '0;
        res_stable_sel = 1'b0;
        res_ptat_en_n  = 1'b1;
        c1             = 2'b00;
        c2             = 2'b00;
        busy           = 1'b0;
        done           = 1'b0;
        if (state != IDLE) begin
            pwrup          = 1'b1;
            res_ptat_en_n  = 1'b0;
            res_stable_sel = (state != SETTLE);
            idac_coarse    = coarse_q;
            idac_out_sel_n = sel_n_q;
            idac_fine      = trim_q ? work : fine_q;
        end
        case (state)
            SETTLE: busy = 1'b1;
            S1: begin
                busy      = 1'b1;
                diode_sel = NDIODE'(1);
                if (swap) c2 = 2'b01;
                else      c1 = 2'b01;
            end
            G1: begin
                busy      = 1'b1;
                diode_sel = NDIODE'(1);
            end
            S2: begin
                busy      = 1'b1;
                diode_sel = diode_n_q;
                if (swap) c1 = 2'b01;
                else      c2 = 2'b01;
            end
            HOLD: begin
                busy      = 1'b1;
                diode_sel = diode_n_q;
                c1        = 2'b10;
                c2        = 2'b10;
            end
            G2, G3: begin
                busy      = 1'b1;
                diode_sel = diode_n_q;
            end
            DONE: begin
                done      = 1'b1;
                idac_fine = trim_code;
            end
            READY: idac_fine = trim_code;
            default: ;
        endcase
    end

endmodule
